pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Hazard/sequencing controller for the 5-stage MIPS pipeline. Drives the IF/ID hold, ID/EX bubble and flush controls.
//  Drives the EX-stage forwarding selects. Tracks the multi-cycle mult/div unit so HI/LO consumers stall until it finishes.
//  Sits beside the pipeline registers. Consumes register fields and control bits already carried through ID/EX, EX/MEM, MEM/WB.
// PARAMETERS
//  MULT_LAT  5   cycles from mult start to HI/LO valid (>=1)
//  DIV_LAT   32  cycles from div start to HI/LO valid (>=1, <=63)
//  CNT_W     32  width of the stall performance counter
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous reset, active-high
//  id_rs        in   5      rs field of instruction in ID
//  id_rt        in   5      rt field of instruction in ID
//  id_use_rs    in   1      ID instruction reads rs
//  id_use_rt    in   1      ID instruction reads rt
//  id_md        in   1      ID instruction is mult/div/mfhi/mflo (needs MD unit)
//  ex_rs        in   5      rs field in EX
//  ex_rt        in   5      rt field in EX
//  ex_rd        in   5      destination in EX
//  ex_rfwr      in   1      EX writes register file
//  ex_mr        in   1      EX is a load
//  ex_md_start  in   1      EX launches mult/div this cycle
//  ex_md_div    in   1      1=divide, 0=multiply (valid with ex_md_start)
//  ex_br_taken  in   1      branch/jump resolved taken in EX
//  mem_rd       in   5      destination in MEM
//  mem_rfwr     in   1      MEM writes register file
//  wb_rd        in   5      destination in WB
//  wb_rfwr      in   1      WB writes register file
//  stall        out  2      00 none, 01 load-use, 10 MD busy; nonzero holds PC+IF/ID and bubbles ID/EX
//  if_flush     out  1      clear IF/ID
//  ex_flush     out  1      clear ID/EX
//  fwd_a        out  2      ALU A source: 00 RF, 01 EX/MEM, 10 MEM/WB
//  fwd_b        out  2      ALU B source, same encoding
//  md_busy      out  1      MD unit computing (registered)
//  md_done      out  1      one-cycle pulse when HI/LO become valid (registered)
//  stall_cnt    out  CNT_W  cycles with stall!=0, wraps at 2^CNT_W
// BEHAVIOUR
//  Reset: all outputs 0, MD counter 0. rst mid-operation aborts any mult/div; md_done is not pulsed.
//  Load-use: ex_mr & ex_rfwr & ex_rd!=0 & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)) -> stall=01. Holds exactly 1 cycle.
//  MD busy: id_md & md_busy -> stall=10. Load-use (01) has priority when both are true.
//  MD counter (6-bit): ex_md_start loads MULT_LAT or DIV_LAT. md_busy=1 from the next cycle.
//  MD counter: decrements each cycle. Transition 1->0 pulses md_done and clears md_busy in the same edge.
//  MD counter: md_busy is 0 in the cycle md_done is 1, so an MD consumer issues then. Total stall = LAT cycles.
//  ex_md_start while busy restarts the counter with the new latency. The earlier op's md_done is dropped.
//  ex_br_taken: if_flush=1, ex_flush=1, stall forced 00; the flush overrides the squashed ID instruction's stall.
//  ex_md_start with ex_br_taken: the EX op is older than the branch and not squashed, so the counter still starts.
//  Forwarding, per source (A uses ex_rs, B uses ex_rt):
//    01 if mem_rfwr & mem_rd!=0 & mem_rd==src.
//    else 10 if wb_rfwr & wb_rd!=0 & wb_rd==src.
//    else 00. The newer stage (MEM) wins.
//  stall, flush and fwd outputs are combinational from inputs and registered state, and are 0 while rst=1.
//  stall_cnt increments on each edge where stall!=0 and wraps to 0 past all-ones.
// STRUCTURE
//  Stall and forward encodings (STALL_NONE/LOAD/MD, FWD_RF/EXMEM/MEMWB) go in ctrl_encode_def.v as `defines.
//  Sub-module md_busy_counter (params MULT_LAT, DIV_LAT): start, div in -> busy, done out.
//  Hazard compare, forwarding mux selects and stall_cnt stay in the top module.
// TESTING
//  Load-use: lw $5 in EX, ID reads rs=5 -> stall=01 for 1 cycle, then 00; fwd_a=10 on the consumer's EX cycle.
//  Load to $0: ex_rd=0 with matching rs=0 -> stall=00, fwd_a=00.
//  Double hit: mem_rd=wb_rd=7, ex_rs=7, both writing -> fwd_a=01; clear mem_rfwr -> fwd_a=10.
//  Div + mflo: start div (DIV_LAT=32), mflo in ID next cycle -> stall=10 for 32 cycles.
//    md_done pulses on cycle 32, stall_cnt=32 afterwards.
//  Branch vs stall: ex_br_taken with load-use also true -> if_flush=ex_flush=1, stall=00.
//  Reset mid-divide: rst at cycle 10 of a div -> md_busy=0, no md_done; stall_cnt=0 after reset.
//  Wrap: CNT_W=4, hold stall 17 cycles -> stall_cnt=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - stall/forward encodings and forwarding helper for the hazard controller
package pipe_hazard_ctrl_pkg;

   localparam int MD_CNT_W = 6;

   localparam logic [1:0] STALL_NONE = 2'b00;
   localparam logic [1:0] STALL_LOAD = 2'b01;
   localparam logic [1:0] STALL_MD   = 2'b10;

   localparam logic [1:0] FWD_RF     = 2'b00;
   localparam logic [1:0] FWD_EXMEM  = 2'b01;
   localparam logic [1:0] FWD_MEMWB  = 2'b10;

   // Forward select for one ALU source; MEM holds the newer result so it wins over WB.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] src,
      input logic [4:0] mem_rd,
      input logic       mem_rfwr,
      input logic [4:0] wb_rd,
      input logic       wb_rfwr
   );
      if (mem_rfwr && (mem_rd != 5'd0) && (mem_rd == src))
         return FWD_EXMEM;
      else if (wb_rfwr && (wb_rd != 5'd0) && (wb_rd == src))
         return FWD_MEMWB;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_counter.sv
// rtl/pipe_hazard_ctrl_md_busy_counter.sv - latency counter tracking the multi-cycle mult/div unit
module pipe_hazard_ctrl_md_busy_counter
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic div,
   output logic busy,
   output logic done
);

   localparam logic [MD_CNT_W-1:0] MULT_L = MD_CNT_W'(MULT_LAT);
   localparam logic [MD_CNT_W-1:0] DIV_L  = MD_CNT_W'(DIV_LAT);

   logic [MD_CNT_W-1:0] cnt;

   // Load on start (a restart drops the older op), count down, pulse done on the 1->0 step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         if (start)
            cnt <= div ? DIV_L : MULT_L;
         else if (cnt != '0)
            cnt <= cnt - 1'b1;
         busy <= start | (cnt > MD_CNT_W'(1));
         done <= ~start & (cnt == MD_CNT_W'(1));
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall, flush and forwarding control for the 5-stage pipeline
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 32,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_md,
   input  logic [4:0]       ex_rs,
   input  logic [4:0]       ex_rt,
   input  logic [4:0]       ex_rd,
   input  logic             ex_rfwr,
   input  logic             ex_mr,
   input  logic             ex_md_start,
   input  logic             ex_md_div,
   input  logic             ex_br_taken,
   input  logic [4:0]       mem_rd,
   input  logic             mem_rfwr,
   input  logic [4:0]       wb_rd,
   input  logic             wb_rfwr,
   output logic [1:0]       stall,
   output logic             if_flush,
   output logic             ex_flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             md_busy,
   output logic             md_done,
   output logic [CNT_W-1:0] stall_cnt
);

   logic load_use;

   // The EX op is older than a taken branch, so it still launches the MD unit.
   pipe_hazard_ctrl_md_busy_counter #(
      .MULT_LAT (MULT_LAT),
      .DIV_LAT  (DIV_LAT)
   ) u_md (
      .clk   (clk),
      .rst   (rst),
      .start (ex_md_start),
      .div   (ex_md_div),
      .busy  (md_busy),
      .done  (md_done)
   );

   // Load in EX whose destination is read by the instruction in ID.
   always_comb begin
      load_use = ex_mr & ex_rfwr & (ex_rd != 5'd0) &
                 ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));
   end

   // Stall priority: taken branch squashes ID, then load-use, then MD busy.
   always_comb begin
      stall    = STALL_NONE;
      if_flush = 1'b0;
      ex_flush = 1'b0;
      if (!rst) begin
         if (ex_br_taken) begin
            if_flush = 1'b1;
            ex_flush = 1'b1;
         end else if (load_use) begin
            stall = STALL_LOAD;
         end else if (id_md && md_busy) begin
            stall = STALL_MD;
         end
      end
   end

   // ALU operand bypass selects for the instruction in EX.
   always_comb begin
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
      if (!rst) begin
         fwd_a = fwd_sel(ex_rs, mem_rd, mem_rfwr, wb_rd, wb_rfwr);
         fwd_b = fwd_sel(ex_rt, mem_rd, mem_rfwr, wb_rd, wb_rfwr);
      end
   end

   // Count stalled cycles; wraps naturally at the counter width.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt <= '0;
      else if (stall != STALL_NONE)
         stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
   logic        id_use_rs, id_use_rt, id_md, ex_rfwr, ex_mr, ex_md_start;
   logic        ex_md_div, ex_br_taken, mem_rfwr, wb_rfwr;

   logic [1:0]  stall, fwd_a, fwd_b;
   logic        if_flush, ex_flush, md_busy, md_done;
   logic [31:0] stall_cnt;

   logic [1:0]  w_stall, w_fwd_a, w_fwd_b;
   logic        w_if_flush, w_ex_flush, w_md_busy, w_md_done;
   logic [3:0]  w_stall_cnt;

   int total = 0;
   int bad   = 0;
   logic seen;

   always #5 clk = ~clk;

   pipe_hazard_ctrl u_dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_md(id_md),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_rfwr(ex_rfwr), .ex_mr(ex_mr),
      .ex_md_start(ex_md_start), .ex_md_div(ex_md_div), .ex_br_taken(ex_br_taken),
      .mem_rd(mem_rd), .mem_rfwr(mem_rfwr), .wb_rd(wb_rd), .wb_rfwr(wb_rfwr),
      .stall(stall), .if_flush(if_flush), .ex_flush(ex_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
   );

   pipe_hazard_ctrl #(.CNT_W(4)) u_w4 (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_md(id_md),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_rfwr(ex_rfwr), .ex_mr(ex_mr),
      .ex_md_start(ex_md_start), .ex_md_div(ex_md_div), .ex_br_taken(ex_br_taken),
      .mem_rd(mem_rd), .mem_rfwr(mem_rfwr), .wb_rd(wb_rd), .wb_rfwr(wb_rfwr),
      .stall(w_stall), .if_flush(w_if_flush), .ex_flush(w_ex_flush), .fwd_a(w_fwd_a), .fwd_b(w_fwd_b),
      .md_busy(w_md_busy), .md_done(w_md_done), .stall_cnt(w_stall_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clr();
      id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_md = 0;
      ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_rfwr = 0; ex_mr = 0;
      ex_md_start = 0; ex_md_div = 0; ex_br_taken = 0;
      mem_rd = 0; mem_rfwr = 0; wb_rd = 0; wb_rfwr = 0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_load_use5();
      ex_mr = 1; ex_rfwr = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1;
   endtask

   initial begin
      rst = 1;
      clr();
      ex_br_taken = 1; set_load_use5(); mem_rd = 3; mem_rfwr = 1; ex_rs = 3;
      #2;
      chk("rst_if_flush", {31'd0, if_flush}, 0);
      chk("rst_ex_flush", {31'd0, ex_flush}, 0);
      chk("rst_stall", {30'd0, stall}, 0);
      chk("rst_fwd_a", {30'd0, fwd_a}, 0);
      chk("rst_md_busy", {31'd0, md_busy}, 0);
      chk("rst_md_done", {31'd0, md_done}, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      clr();
      cyc(); cyc();
      rst = 0;
      cyc();

      // load-use on $5, then bubble, then forward from WB
      set_load_use5(); #1;
      chk("lu_stall", {30'd0, stall}, 1);
      cyc();
      clr(); mem_rd = 5; mem_rfwr = 1; id_rs = 5; id_use_rs = 1; #1;
      chk("lu_release", {30'd0, stall}, 0);
      cyc();
      clr(); ex_rs = 5; wb_rd = 5; wb_rfwr = 1; #1;
      chk("lu_fwd_a", {30'd0, fwd_a}, 2);
      chk("lu_fwd_b", {30'd0, fwd_b}, 0);
      chk("lu_cnt", stall_cnt, 1);

      // load to $0 never stalls or forwards
      clr(); ex_mr = 1; ex_rfwr = 1; ex_rd = 0; id_rs = 0; id_use_rs = 1;
      mem_rd = 0; mem_rfwr = 1; wb_rd = 0; wb_rfwr = 1; ex_rs = 0; #1;
      chk("r0_stall", {30'd0, stall}, 0);
      chk("r0_fwd_a", {30'd0, fwd_a}, 0);

      // rt-only hazard and the use flag
      clr(); ex_mr = 1; ex_rfwr = 1; ex_rd = 9; id_rt = 9; id_use_rt = 1; #1;
      chk("rt_stall", {30'd0, stall}, 1);
      id_use_rt = 0; #1;
      chk("rt_unused", {30'd0, stall}, 0);

      // both MEM and WB write $7: MEM wins, then WB
      clr(); mem_rd = 7; wb_rd = 7; mem_rfwr = 1; wb_rfwr = 1; ex_rs = 7; ex_rt = 7; #1;
      chk("dbl_fwd_a", {30'd0, fwd_a}, 1);
      chk("dbl_fwd_b", {30'd0, fwd_b}, 1);
      mem_rfwr = 0; #1;
      chk("wb_fwd_a", {30'd0, fwd_a}, 2);
      ex_rt = 3; #1;
      chk("nohit_fwd_b", {30'd0, fwd_b}, 0);

      // taken branch overrides load-use
      clr(); set_load_use5(); ex_br_taken = 1; #1;
      chk("br_if_flush", {31'd0, if_flush}, 1);
      chk("br_ex_flush", {31'd0, ex_flush}, 1);
      chk("br_stall", {30'd0, stall}, 0);
      cyc();
      chk("br_cnt", stall_cnt, 1);

      // div restarted by mult: only the mult completion is signalled
      clr(); ex_md_start = 1; ex_md_div = 1;
      cyc();
      clr(); #1;
      chk("md_busy_on", {31'd0, md_busy}, 1);
      id_md = 1; set_load_use5(); #1;
      chk("prio_load", {30'd0, stall}, 1);
      ex_mr = 0; #1;
      chk("md_stall", {30'd0, stall}, 2);
      clr();
      cyc(); cyc();
      ex_md_start = 1; ex_md_div = 0;
      cyc();
      clr();
      repeat (4) cyc();
      chk("mult_busy", {31'd0, md_busy}, 1);
      chk("mult_not_done", {31'd0, md_done}, 0);
      cyc();
      chk("mult_done", {31'd0, md_done}, 1);
      chk("mult_idle", {31'd0, md_busy}, 0);
      seen = 0;
      repeat (30) begin
         cyc();
         seen = seen | md_done;
      end
      chk("restart_drop", {31'd0, seen}, 0);

      // reset during a divide
      clr(); ex_md_start = 1; ex_md_div = 1;
      cyc();
      clr(); id_md = 1;
      repeat (10) cyc();
      rst = 1; #1;
      chk("rstdiv_busy", {31'd0, md_busy}, 0);
      chk("rstdiv_stall", {30'd0, stall}, 0);
      chk("rstdiv_cnt", stall_cnt, 0);
      cyc();
      clr(); rst = 0;
      seen = 0;
      repeat (40) begin
         cyc();
         seen = seen | md_done | md_busy;
      end
      chk("rstdiv_no_done", {31'd0, seen}, 0);
      chk("rstdiv_cnt_after", stall_cnt, 0);

      // full divide with mflo waiting in ID; branch in same cycle does not cancel it
      clr(); ex_md_start = 1; ex_md_div = 1; ex_br_taken = 1;
      cyc();
      clr(); id_md = 1;
      seen = 0;
      for (int i = 0; i < 32; i++) begin
         #1;
         chk($sformatf("div_stall_%0d", i), {30'd0, stall}, 2);
         seen = seen | md_done;
         cyc();
      end
      chk("div_early_done", {31'd0, seen}, 0);
      chk("div_done", {31'd0, md_done}, 1);
      chk("div_idle", {31'd0, md_busy}, 0);
      chk("div_release", {30'd0, stall}, 0);
      chk("div_cnt", stall_cnt, 32);
      chk("div_cnt_w4", {28'd0, w_stall_cnt}, 0);
      cyc();
      chk("div_done_pulse", {31'd0, md_done}, 0);

      // 4-bit counter wraps after 17 stalled cycles
      rst = 1; #1;
      cyc();
      rst = 0; clr(); set_load_use5();
      repeat (17) cyc();
      chk("wrap_w4", {28'd0, w_stall_cnt}, 1);
      chk("wrap_w32", stall_cnt, 17);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
